lifo_stack: RTL and testbench

Synchronous LIFO data store that pairs with the up/down pointer counter. It accepts push/pop commands and holds the data the pointer addresses. It reports occupancy, top-of-stack, full/empty flags, and overflow/underflow pulses. The stall/clr semantics match the counter's, so one control FSM can drive both without extra glue.

---
 rtl/lifo_stack_if.sv | 31 +++
 rtl/lifo_stack.sv | 70 +++++++
 tb/tb_lifo_stack.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lifo_stack_if.sv
// Command/status bundle between a stack controller and lifo_stack.
// Latency: n/a (wires only).
// Backpressure: none; the stall line freezes the stack, and ovf/unf flag rejected commands.
interface lifo_stack_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
);
  logic                  clr;
  logic                  stall;
  logic                  push;
  logic                  pop;
  logic [WIDTH-1:0]      din;
  logic [WIDTH-1:0]      dout;
  logic [DEPTH_LOG2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  ovf;
  logic                  unf;

  // Controller side: issues commands, observes stack status.
  modport master (
    output clr, stall, push, pop, din,
    input  dout, count, full, empty, ovf, unf
  );

  // Stack side: consumes commands, reports status.
  modport slave (
    input  clr, stall, push, pop, din,
    output dout, count, full, empty, ovf, unf
  );
endinterface

// File: rtl/lifo_stack.sv
// Synchronous LIFO store addressed by a saturating stack pointer.
// Latency: push/pop visible on dout/count/flags one edge after capture; ovf/unf combinational.
// Backpressure: stall freezes all state; push when full / pop when empty are dropped and flagged.
module lifo_stack #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input logic        clk,
  input logic        rst,
  lifo_stack_if.slave bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   SP_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   SP_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2:0]   sp;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] top_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic                  full;
  logic                  empty;
  logic                  active;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  // Low bits of sp wrap cleanly: when full they are 0, so top_idx becomes DEPTH-1.
  assign top_idx = sp[DEPTH_LOG2-1:0] - IDX_ONE;
  assign wr_idx  = sp[DEPTH_LOG2-1:0];
  // Commands only take effect on an edge that is not reset, stalled or cleared.
  assign active  = ~rst & ~bus.stall & ~bus.clr;

  // Stack pointer: reset > stall > clr > replace/push/pop, saturating by rejection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (bus.stall) begin
      sp <= sp;
    end else if (bus.clr) begin
      sp <= '0;
    end else if (bus.push && bus.pop) begin
      if (empty) sp <= SP_ONE;
    end else if (bus.push) begin
      if (!full) sp <= sp + SP_ONE;
    end else if (bus.pop) begin
      if (!empty) sp <= sp - SP_ONE;
    end
  end

  // Storage write: replace the top on push+pop, else append when room; never reset.
  always_ff @(posedge clk) begin
    if (active && bus.push) begin
      if (bus.pop && !empty) begin
        mem[top_idx] <= bus.din;
      end else if (!full) begin
        mem[wr_idx] <= bus.din;
      end
    end
  end

  // Status outputs come straight from sp; error pulses ignore stall/clr, masked only by reset.
  always_comb begin
    bus.count = sp;
    bus.full  = full;
    bus.empty = empty;
    bus.dout  = empty ? '0 : mem[top_idx];
    bus.ovf   = ~rst & bus.push & ~bus.pop & full;
    bus.unf   = ~rst & bus.pop & ~bus.push & empty;
  end
endmodule

// File: tb/tb_lifo_stack.sv
// Randomized + directed bench for lifo_stack against a queue-based reference model.
// Latency: checks ovf/unf before each edge and registered outputs 1 time unit after it.
// Backpressure: stall/clr/rst exercised directly and at random.
module tb_lifo_stack;
  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lifo_stack_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  lifo_stack #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference stack: back of the queue is the top.
  logic [WIDTH-1:0] ref_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: apply inputs, check combinational pulses, clock, update model, check state.
  task automatic step(input logic r, input logic c, input logic s,
                      input logic ps, input logic pp, input logic [WIDTH-1:0] d);
    logic exp_ovf;
    logic exp_unf;
    int   sz;
    rst       = r;
    bus.clr   = c;
    bus.stall = s;
    bus.push  = ps;
    bus.pop   = pp;
    bus.din   = d;
    #1;
    sz      = ref_q.size();
    exp_ovf = !r && ps && !pp && (sz == DEPTH);
    exp_unf = !r && pp && !ps && (sz == 0);
    check("ovf", {31'b0, bus.ovf}, {31'b0, exp_ovf});
    check("unf", {31'b0, bus.unf}, {31'b0, exp_unf});
    @(posedge clk);
    if (r) ref_q.delete();
    else if (s) begin end
    else if (c) ref_q.delete();
    else if (ps && pp) begin
      if (sz > 0) ref_q[sz-1] = d;
      else ref_q.push_back(d);
    end else if (ps) begin
      if (sz < DEPTH) ref_q.push_back(d);
    end else if (pp) begin
      if (sz > 0) void'(ref_q.pop_back());
    end
    #1;
    sz = ref_q.size();
    check("count", 32'(bus.count), 32'(sz));
    check("dout",  32'(bus.dout), (sz > 0) ? 32'(ref_q[sz-1]) : 32'd0);
    check("full",  {31'b0, bus.full},  {31'b0, (sz == DEPTH)});
    check("empty", {31'b0, bus.empty}, {31'b0, (sz == 0)});
    @(negedge clk);
  endtask

  task automatic push1(input logic [WIDTH-1:0] d); step(0, 0, 0, 1, 0, d); endtask
  task automatic pop1();                           step(0, 0, 0, 0, 1, 8'h00); endtask

  initial begin
    bus.clr = 0; bus.stall = 0; bus.push = 0; bus.pop = 0; bus.din = '0;
    @(negedge clk);

    // Reset for two cycles, then release.
    step(1, 0, 0, 0, 0, 8'h00);
    step(1, 0, 0, 1, 1, 8'hAA);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_dout",  32'(bus.dout),  32'd0);
    step(0, 0, 0, 0, 0, 8'h00);

    // Ordered push/pop.
    push1(8'h11); push1(8'h22); push1(8'h33);
    check("top_33", 32'(bus.dout), 32'h33);
    pop1(); check("top_22", 32'(bus.dout), 32'h22);
    pop1(); check("top_11", 32'(bus.dout), 32'h11);
    pop1(); check("top_0",  32'(bus.dout), 32'h00);

    // Fill, then overflow.
    for (int i = 0; i < DEPTH; i++) push1(8'(8'h40 + i));
    check("full_flag", {31'b0, bus.full}, 32'd1);
    push1(8'hEE);
    check("ovf_top", 32'(bus.dout), 32'h47);
    // Reset masks ovf even when push on full.
    step(1, 0, 0, 1, 0, 8'h01);

    // Underflow, then push+pop on empty.
    pop1();
    step(0, 0, 0, 1, 1, 8'h5A);
    check("pp_empty", 32'(bus.dout), 32'h5A);

    // Stall with push, then replace.
    push1(8'h6B);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 8'h99);
    check("stall_cnt", 32'(bus.count), 32'd2);
    step(0, 0, 0, 1, 1, 8'hC3);
    check("replace", 32'(bus.dout), 32'hC3);

    // clr with push; then stalled clr.
    push1(8'h01); push1(8'h02);
    step(0, 1, 0, 1, 0, 8'h77);
    check("clr_cnt", 32'(bus.count), 32'd0);
    for (int i = 0; i < 4; i++) push1(8'(8'h80 + i));
    step(0, 1, 1, 1, 0, 8'h77);
    check("stall_clr", 32'(bus.count), 32'd4);

    // Reset mid-sequence with stall and push held.
    push1(8'h90);
    step(1, 0, 1, 1, 0, 8'h91);
    check("mid_rst", 32'(bus.count), 32'd0);

    // Random traffic, biased toward push/pop with occasional control events.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 65 : 35)),
           ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 65)),
           8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
